useq_next: RTL

Next-address logic for the microsequencer. Decodes the branch field of the current microinstruction together with ALU flags, the opcode and the memory handshake, and drives `load_incr`/`upc_next` into the micro-program counter register in the same cycle. Holds a 4-entry micro-return stack for micro-subroutines and a wait-timeout counter for memory stalls.

---
 rtl/useq_next.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/useq_next.sv
// useq_next - next-address logic for the microsequencer.
//
// Decodes the branch field of the current microinstruction with the ALU
// flags, the macro opcode and the memory handshake. It drives load_incr and
// upc_next combinationally into the micro-PC register in the same cycle.
// It also keeps a micro-return stack for micro-subroutines and a
// wait-timeout counter for memory stalls.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears stack, counters, error flags
//   upc        current micro-PC
//   br_type    branch field: 0 NEXT, 1 JUMP, 2 BZ, 3 BN, 4 DISPATCH,
//              5 CALL, 6 RET, 7 WAIT
//   br_target  branch / call target address
//   flag_z     ALU zero flag
//   flag_n     ALU negative flag
//   opcode     macro opcode for DISPATCH (loads {1'b1, opcode})
//   mem_ready  memory access complete
//   load_incr  1 = micro-PC loads upc_next, 0 = micro-PC increments
//   upc_next   load address (forced to 0 when load_incr = 0)
//   stk_depth  current return-stack occupancy
//   err        sticky flags: bit0 stack over/underflow, bit1 wait timeout
//
// Handshake: no valid/ready pair. Every clk edge consumes one
// microinstruction. The outputs are valid while the inputs are stable.
// Internal state (stack, depth, wait counter, err) commits on that edge.
module useq_next #(
  parameter int STACK_DEPTH = 4,
  parameter int WAIT_LIMIT  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] upc,
  input  logic [2:0] br_type,
  input  logic [4:0] br_target,
  input  logic       flag_z,
  input  logic       flag_n,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       load_incr,
  output logic [4:0] upc_next,
  output logic [2:0] stk_depth,
  output logic [1:0] err
);

  localparam int IDX_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = IDX_W + 1;

  localparam logic [2:0] BR_NEXT     = 3'd0;
  localparam logic [2:0] BR_JUMP     = 3'd1;
  localparam logic [2:0] BR_BZ       = 3'd2;
  localparam logic [2:0] BR_BN       = 3'd3;
  localparam logic [2:0] BR_DISPATCH = 3'd4;
  localparam logic [2:0] BR_CALL     = 3'd5;
  localparam logic [2:0] BR_RET      = 3'd6;
  localparam logic [2:0] BR_WAIT     = 3'd7;

  logic [4:0]         stack [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth;
  logic [3:0]         wait_cnt;
  logic [3:0]         wait_cnt_nxt;
  logic               push;
  logic               pop;
  logic               stk_err;
  logic               timeout;
  logic               full;
  logic               empty;
  logic [IDX_W-1:0]   top_idx;
  logic [4:0]         upc_inc;

  assign full    = (depth == DEPTH_W'(STACK_DEPTH));
  assign empty   = (depth == '0);
  assign top_idx = IDX_W'(depth - DEPTH_W'(1));
  // Return address wraps: a CALL from 31 returns to 0.
  assign upc_inc = upc + 5'd1;

  // Branch decode and stack/counter control.
  always_comb begin
    load_incr    = 1'b0;
    upc_next     = 5'd0;
    push         = 1'b0;
    pop          = 1'b0;
    stk_err      = 1'b0;
    timeout      = 1'b0;
    wait_cnt_nxt = 4'd0;
    case (br_type)
      BR_NEXT: begin
        load_incr = 1'b0;
      end
      BR_JUMP: begin
        load_incr = 1'b1;
        upc_next  = br_target;
      end
      BR_BZ: begin
        load_incr = flag_z;
        upc_next  = flag_z ? br_target : 5'd0;
      end
      BR_BN: begin
        load_incr = flag_n;
        upc_next  = flag_n ? br_target : 5'd0;
      end
      BR_DISPATCH: begin
        load_incr = 1'b1;
        upc_next  = {1'b1, opcode};
      end
      BR_CALL: begin
        // The jump is always taken. Only the push is dropped on overflow.
        load_incr = 1'b1;
        upc_next  = br_target;
        if (full) stk_err = 1'b1;
        else      push    = 1'b1;
      end
      BR_RET: begin
        // Underflow restarts the microprogram at address 0.
        load_incr = 1'b1;
        if (empty) begin
          upc_next = 5'd0;
          stk_err  = 1'b1;
        end else begin
          upc_next = stack[top_idx];
          pop      = 1'b1;
        end
      end
      BR_WAIT: begin
        if (!mem_ready) begin
          load_incr = 1'b1;
          if (wait_cnt == 4'(WAIT_LIMIT - 1)) begin
            // Give up on the stalled access and restart.
            upc_next = 5'd0;
            timeout  = 1'b1;
          end else begin
            upc_next     = upc;
            wait_cnt_nxt = wait_cnt + 4'd1;
          end
        end
      end
      default: begin
        load_incr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= 5'd0;
      depth    <= '0;
      wait_cnt <= 4'd0;
      err      <= 2'b00;
    end else begin
      if (push) begin
        stack[depth[IDX_W-1:0]] <= upc_inc;
        depth                   <= depth + DEPTH_W'(1);
      end else if (pop) begin
        depth <= depth - DEPTH_W'(1);
      end
      wait_cnt <= wait_cnt_nxt;
      err      <= err | {timeout, stk_err};
    end
  end

  // With STACK_DEPTH = 8 the full count does not fit the 3-bit port.
  assign stk_depth = 3'(depth);

endmodule
